seq_detect_dual: RTL
====================

# seq_detect_dual

Parametrised serial pattern recogniser that watches a 1-bit input stream for either of two runtime-programmable N-bit patterns. It supports overlapping or non-overlapping detection and qualifies input bits with a valid strobe. It reports which pattern(s) matched and keeps a saturating match counter. It sits on a serial input path and replaces fixed-pattern 3-bit recognisers such as the 010/101 detector.

## Interface
- N, default 3: pattern length in bits, legal range 2..16.
- CW, default 8: width of the match counter, legal range 1..32.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  capture pat_a, pat_b and overlap; restart detection.
- pat_a  input  N  pattern A. Bit N-1 is the first bit received, bit 0 the last.
- pat_b  input  N  pattern B, same bit order as pat_a.
- overlap  input  1  1 = overlapping matches allowed; 0 = history flushed after each match. Sampled only on load.
- x  input  1  serial data bit.
- x_valid  input  1  x is sampled only when this is 1.
- clr_count  input  1  synchronous clear of match_count.
- y  output  1  registered match pulse.
- which  output  2  bit0 = pattern A matched, bit1 = pattern B matched. Valid while y=1, 0 otherwise.
- match_count  output  CW  saturating count of match events.
- armed  output  1  1 once at least N valid bits have been collected since the last load or flush.

## Operation
- Registered configuration: cfg_a, cfg_b, cfg_ovl. History register hist[N-1:0]; on each accepted bit, hist <= {hist[N-2:0], x}, so the newest bit is in bit 0. Fill counter fill, width ceil(log2(N+1)).
- State machine states:
  - IDLE
    - Entered on reset.
    - x_valid is ignored; y=0; armed=0.
    - load -> FILL.
  - FILL
    - Each accepted bit shifts into hist and increments fill.
    - When the accepted bit makes fill reach N, evaluate the new window (as in ARMED) and go to ARMED.
  - ARMED
    - Each accepted bit shifts into hist. The new window W is compared against cfg_a and cfg_b.
    - Any equality sets y=1 and which={W==cfg_b, W==cfg_a}.
    - On a match with cfg_ovl=0: clear fill and hist, go to FILL.
    - On a match with cfg_ovl=1: stay in ARMED.
- load in any non-reset state:
  - Captures the configuration, clears hist and fill, goes to FILL.
  - Does not touch match_count.
  - Has priority over a same-cycle x_valid; that bit is discarded.
- One match event per accepted bit. If pat_a == pat_b, both bits of which are set and match_count increments by 1.
- match_count:
  - Increments by 1 per match event.
  - Saturates at 2^CW-1; no wrap.
  - clr_count has priority over a same-cycle increment; the result is 0.
- Cycles with x_valid=0 hold all state. y and which return to 0.
- armed = 1 exactly when the state is ARMED.

## Timing
- Reset (asynchronous, immediate): y=0, which=0, match_count=0, armed=0, hist=0, fill=0, state=IDLE, config registers=0.
- Reset asserted mid-stream: partial history and count are lost. A new load is required after reset is released.
- Latency:
  - y and which update on the same rising edge that samples the completing bit.
  - They stay high for exactly one cycle unless the next accepted bit also matches.
  - Back-to-back matches (overlap=1) hold y high on consecutive cycles.
- match_count reflects a match on that same edge.
- armed rises on the edge that accepts the Nth bit after load or flush.
- In non-overlap mode, the earliest next match is N accepted bits after the flushing match.

## Test plan
- Reset and pre-load: assert reset, then drive x_valid=1 with x=0,1,0 before any load -> y=0, which=0, match_count=0, armed=0 throughout.
- Overlap mode: load N=3, pat_a=010, pat_b=101, overlap=1; stream 0,1,0,1,0 -> y=1 after bits 3, 4 and 5 with which=01, 10, 01; match_count=3; armed rises after bit 3.
- Non-overlap mode: same patterns with overlap=0; stream 0,1,0,1,0,1 -> match after bit 3 (which=01) and after bit 6 (window 101, which=10), no match after bits 4 and 5; match_count=2.
- Valid gaps and load priority: insert x_valid=0 cycles between the bits of 0,1,0 -> a single match on the last valid bit and y=0 on idle cycles. Asserting load together with the completing x_valid bit -> no match, fill=0.
- Equal patterns and saturation: CW=2, pat_a=pat_b=11, overlap=1; stream six 1s -> which=11 on each match, match_count goes 1,2,3,3,3; clr_count together with a match -> match_count=0.
- Async reset mid-operation: assert reset between clock edges while ARMED with match_count=2 -> all outputs 0 immediately; after release, stream 0,1,0 without load -> no match.

Source files
------------

// File: rtl/seq_detect_dual.sv
// seq_detect_dual: serial recogniser for two programmable N-bit patterns.
// It supports overlapping or flushing detection and has a saturating match counter.
module seq_detect_dual #(
  parameter int N  = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [N-1:0]  pat_a,
  input  logic [N-1:0]  pat_b,
  input  logic          overlap,
  input  logic          x,
  input  logic          x_valid,
  input  logic          clr_count,
  output logic          y,
  output logic [1:0]    which,
  output logic [CW-1:0] match_count,
  output logic          armed
);

  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);
  localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ARMED
  } state_t;

  state_t        state_q;
  logic [N-1:0]  cfg_a_q;
  logic [N-1:0]  cfg_b_q;
  logic          cfg_ovl_q;
  logic [N-1:0]  hist_q;
  logic [FW-1:0] fill_q;
  logic          y_q;
  logic [1:0]    which_q;
  logic [CW-1:0] count_q;

  logic [N-1:0]  win_d;
  logic          hitA;
  logic          hitB;
  logic          evalNow;
  logic          matchEvt;

  // Form the window the current bit would complete and decide whether it counts as a match event.
  // A bit is only evaluated once the history holds N bits, and never when load discards it.
  always_comb begin
    win_d    = {hist_q[N-2:0], x};
    hitA     = (win_d == cfg_a_q);
    hitB     = (win_d == cfg_b_q);
    evalNow  = x_valid && !load &&
               ((state_q == ARMED) || ((state_q == FILL) && (fill_q == FILL_LAST)));
    matchEvt = evalNow && (hitA || hitB);
  end

  // Main FSM: configuration capture, history shifting, flushing and the registered match outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cfg_a_q   <= '0;
      cfg_b_q   <= '0;
      cfg_ovl_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      y_q       <= 1'b0;
      which_q   <= 2'b00;
    end else begin
      y_q     <= matchEvt;
      which_q <= matchEvt ? {hitB, hitA} : 2'b00;
      if (load) begin
        cfg_a_q   <= pat_a;
        cfg_b_q   <= pat_b;
        cfg_ovl_q <= overlap;
        hist_q    <= '0;
        fill_q    <= '0;
        state_q   <= FILL;
      end else if (x_valid) begin
        case (state_q)
          FILL: begin
            if (fill_q == FILL_LAST) begin
              if (matchEvt && !cfg_ovl_q) begin
                hist_q  <= '0;
                fill_q  <= '0;
                state_q <= FILL;
              end else begin
                hist_q  <= win_d;
                fill_q  <= FILL_FULL;
                state_q <= ARMED;
              end
            end else begin
              hist_q <= win_d;
              fill_q <= fill_q + FW'(1);
            end
          end
          ARMED: begin
            if (matchEvt && !cfg_ovl_q) begin
              hist_q  <= '0;
              fill_q  <= '0;
              state_q <= FILL;
            end else begin
              hist_q <= win_d;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Saturating match counter; a synchronous clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr_count) begin
      count_q <= '0;
    end else if (matchEvt && (count_q != COUNT_MAX)) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign y           = y_q;
  assign which       = which_q;
  assign match_count = count_q;
  assign armed       = (state_q == ARMED);

endmodule
